uart_cmd_decoder: RTL



---
 rtl/uart_cmd_decoder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_decoder.sv
//------------------------------------------------------------------------------
// Module      : uart_cmd_decoder
// Description : Assembles SYNC/CMD/ARG/CHK packets from a UART byte stream
//               and drives the Pong game control registers.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_cmd_decoder #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter logic [7:0] MAX_Y        = 8'd200,
    parameter logic [7:0] INIT_Y       = 8'd100,
    parameter int         TIMEOUT_CLKS = 17360
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       data_valid,
    input  logic [7:0] data_byte_op,
    output logic [7:0] paddle1_y,
    output logic [7:0] paddle2_y,
    output logic       game_run,
    output logic       game_reset,
    output logic       cmd_ok,
    output logic       cmd_error
);

    localparam int          c_CNT_W    = 15;
    localparam logic [14:0] c_TMO_LAST = 15'(TIMEOUT_CLKS - 1);

    localparam logic [7:0] c_CMD_P1    = 8'h01;
    localparam logic [7:0] c_CMD_P2    = 8'h02;
    localparam logic [7:0] c_CMD_RUN   = 8'h03;
    localparam logic [7:0] c_CMD_RESET = 8'h04;

    typedef enum logic [1:0] {
        S_WAIT_SYNC = 2'd0,
        S_GET_CMD   = 2'd1,
        S_GET_ARG   = 2'd2,
        S_GET_CHK   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_tmo_cnt;
    logic [c_CNT_W-1:0]   w_tmo_cnt_nxt;
    logic [7:0]           r_cmd;
    logic [7:0]           w_cmd_nxt;
    logic [7:0]           r_arg;
    logic [7:0]           w_arg_nxt;
    logic [7:0]           r_p1;
    logic [7:0]           w_p1_nxt;
    logic [7:0]           r_p2;
    logic [7:0]           w_p2_nxt;
    logic                 r_run;
    logic                 w_run_nxt;
    logic                 r_greset;
    logic                 w_greset_nxt;
    logic                 r_ok;
    logic                 w_ok_nxt;
    logic                 r_err;
    logic                 w_err_nxt;

    logic [7:0]           w_arg_clamped;
    logic                 w_chk_match;
    logic                 w_tmo_hit;

    assign w_arg_clamped = (r_arg > MAX_Y) ? MAX_Y : r_arg;
    assign w_chk_match   = (data_byte_op == (r_cmd ^ r_arg));
    assign w_tmo_hit     = (r_tmo_cnt == c_TMO_LAST);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= S_WAIT_SYNC;
            r_tmo_cnt <= '0;
            r_cmd     <= '0;
            r_arg     <= '0;
            r_p1      <= INIT_Y;
            r_p2      <= INIT_Y;
            r_run     <= 1'b0;
            r_greset  <= 1'b0;
            r_ok      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tmo_cnt <= w_tmo_cnt_nxt;
            r_cmd     <= w_cmd_nxt;
            r_arg     <= w_arg_nxt;
            r_p1      <= w_p1_nxt;
            r_p2      <= w_p2_nxt;
            r_run     <= w_run_nxt;
            r_greset  <= w_greset_nxt;
            r_ok      <= w_ok_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tmo_cnt_nxt = (r_state == S_WAIT_SYNC) ? '0 : r_tmo_cnt + 15'd1;
        w_cmd_nxt     = r_cmd;
        w_arg_nxt     = r_arg;
        w_p1_nxt      = r_p1;
        w_p2_nxt      = r_p2;
        w_run_nxt     = r_run;
        w_greset_nxt  = 1'b0;
        w_ok_nxt      = 1'b0;
        w_err_nxt     = 1'b0;

        case (r_state)
            S_WAIT_SYNC: begin
                if (data_valid && (data_byte_op == SYNC_BYTE)) begin
                    w_state_nxt   = S_GET_CMD;
                    w_tmo_cnt_nxt = '0;
                end
            end

            S_GET_CMD: begin
                if (data_valid) begin
                    w_cmd_nxt     = data_byte_op;
                    w_state_nxt   = S_GET_ARG;
                    w_tmo_cnt_nxt = '0;
                end else if (w_tmo_hit) begin
                    w_state_nxt   = S_WAIT_SYNC;
                    w_tmo_cnt_nxt = '0;
                    w_err_nxt     = 1'b1;
                end
            end

            S_GET_ARG: begin
                if (data_valid) begin
                    w_arg_nxt     = data_byte_op;
                    w_state_nxt   = S_GET_CHK;
                    w_tmo_cnt_nxt = '0;
                end else if (w_tmo_hit) begin
                    w_state_nxt   = S_WAIT_SYNC;
                    w_tmo_cnt_nxt = '0;
                    w_err_nxt     = 1'b1;
                end
            end

            S_GET_CHK: begin
                if (data_valid) begin
                    w_state_nxt   = S_WAIT_SYNC;
                    w_tmo_cnt_nxt = '0;
                    if (!w_chk_match) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        // Unknown commands leave every control register untouched.
                        case (r_cmd)
                            c_CMD_P1: begin
                                w_p1_nxt = w_arg_clamped;
                                w_ok_nxt = 1'b1;
                            end
                            c_CMD_P2: begin
                                w_p2_nxt = w_arg_clamped;
                                w_ok_nxt = 1'b1;
                            end
                            c_CMD_RUN: begin
                                w_run_nxt = r_arg[0];
                                w_ok_nxt  = 1'b1;
                            end
                            c_CMD_RESET: begin
                                w_greset_nxt = 1'b1;
                                w_run_nxt    = 1'b0;
                                w_p1_nxt     = INIT_Y;
                                w_p2_nxt     = INIT_Y;
                                w_ok_nxt     = 1'b1;
                            end
                            default: begin
                                w_err_nxt = 1'b1;
                            end
                        endcase
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt   = S_WAIT_SYNC;
                    w_tmo_cnt_nxt = '0;
                    w_err_nxt     = 1'b1;
                end
            end

            default: begin
                w_state_nxt   = S_WAIT_SYNC;
                w_tmo_cnt_nxt = '0;
            end
        endcase
    end

    assign paddle1_y  = r_p1;
    assign paddle2_y  = r_p2;
    assign game_run   = r_run;
    assign game_reset = r_greset;
    assign cmd_ok     = r_ok;
    assign cmd_error  = r_err;

endmodule

`default_nettype wire
